// File: rtl/taillight_pkg.sv
// rtl/taillight_pkg.sv - shared encodings, lamp patterns and sequence tables for the taillight decoder
package taillight_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_TURN       = 2'd1,
        MODE_BRAKE      = 2'd2,
        MODE_BRAKE_TURN = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_AMB,
        S_BRAKE,
        S_TURN,
        S_BTURN
    } state_e;

    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_3   = 3'b011;
    localparam logic [2:0] PAT_7   = 3'b111;
    localparam logic [2:0] PAT_6   = 3'b110;
    localparam logic [2:0] PAT_4   = 3'b100;

    // Element [0] is phase 0.
    localparam logic [3:0][2:0] TURN_SEQ  = {PAT_OFF, PAT_7, PAT_3, PAT_1};
    localparam logic [3:0][2:0] BTURN_SEQ = {PAT_OFF, PAT_4, PAT_6, PAT_7};

    function automatic logic [2:0] next_pat(input state_e st, input logic [1:0] ph);
        logic [1:0] ph_n;
        ph_n = ph + 2'd1;
        return (st == S_BTURN) ? BTURN_SEQ[ph_n] : TURN_SEQ[ph_n];
    endfunction

    function automatic mode_e mode_of(input state_e st);
        case (st)
            S_TURN:         return MODE_TURN;
            S_BTURN:        return MODE_BRAKE_TURN;
            S_AMB, S_BRAKE: return MODE_BRAKE;
            default:        return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/taillight_side_decoder.sv
// rtl/taillight_side_decoder.sv - one side: input register, hold counter, protocol FSM and err pulse
module taillight_side_decoder
    import taillight_pkg::*;
#(
    parameter int STEP_CYCLES = 5,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pattern,
    output logic [1:0] mode,
    output logic [1:0] phase,
    output logic       seq_err
);

    localparam logic [CNT_W-1:0] STEP     = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(STEP_CYCLES + 1);

    logic [2:0]       pat_q;
    logic [2:0]       pat_prev_q;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_cur;
    state_e           state_q;
    state_e           state_d;
    logic [1:0]       phase_q;
    logic [1:0]       phase_d;
    logic             first_q;
    logic             first_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             err_d;
    logic             chg;
    logic             over;
    logic             resync;
    logic [2:0]       exp_pat;
    mode_e            mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q      <= PAT_OFF;
            pat_prev_q <= PAT_OFF;
            hold_q     <= '0;
            state_q    <= S_OFF;
            phase_q    <= 2'd0;
            first_q    <= 1'b1;
            ovf_q      <= 1'b0;
            mode_q     <= MODE_OFF;
            seq_err    <= 1'b0;
        end else begin
            pat_q      <= pattern;
            pat_prev_q <= pat_q;
            hold_q     <= hold_cur;
            state_q    <= state_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            ovf_q      <= ovf_d;
            mode_q     <= mode_of(state_d);
            seq_err    <= err_d;
        end
    end

    // hold_q is the stable length of the previous pattern, so on a change it is the departed segment length.
    always_comb begin
        chg      = (pat_q != pat_prev_q);
        hold_cur = chg ? CNT_W'(1) : ((hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + CNT_W'(1));
        over     = !chg && (hold_cur > STEP);
        exp_pat  = next_pat(state_q, phase_q);
        state_d  = state_q;
        phase_d  = phase_q;
        first_d  = first_q;
        ovf_d    = ovf_q;
        err_d    = 1'b0;
        resync   = 1'b0;

        case (state_q)
            S_OFF: begin
                if (chg) resync = 1'b1;
            end
            S_AMB, S_BRAKE: begin
                if (state_q == S_AMB && over) begin
                    state_d = S_BRAKE;
                end else if (chg) begin
                    if (pat_q == PAT_6 || pat_q == PAT_OFF || pat_q == PAT_1) resync = 1'b1;
                    else                                                      err_d  = 1'b1;
                end
            end
            S_TURN, S_BTURN: begin
                if (chg) begin
                    if (pat_q == exp_pat) begin
                        phase_d = phase_q + 2'd1;
                        first_d = 1'b0;
                        ovf_d   = 1'b0;
                        if (!first_q && hold_q != STEP) err_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        resync = 1'b1;
                    end
                end else if (over) begin
                    if (pat_q == PAT_OFF) begin
                        state_d = S_OFF;
                        phase_d = 2'd0;
                    end else if (pat_q == PAT_7) begin
                        state_d = S_BRAKE;
                        phase_d = 2'd0;
                    end else if (!ovf_q) begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_OFF;
                phase_d = 2'd0;
            end
        endcase

        // Re-entry treats the new pattern as if seen from S_OFF and starts a fresh, unchecked segment.
        if (resync) begin
            first_d = 1'b1;
            ovf_d   = 1'b0;
            phase_d = 2'd0;
            case (pat_q)
                PAT_OFF: state_d = S_OFF;
                PAT_1:   state_d = S_TURN;
                PAT_3: begin
                    state_d = S_TURN;
                    phase_d = 2'd1;
                end
                PAT_6: begin
                    state_d = S_BTURN;
                    phase_d = 2'd1;
                end
                PAT_4: begin
                    state_d = S_BTURN;
                    phase_d = 2'd2;
                end
                PAT_7:   state_d = S_AMB;
                default: begin
                    state_d = S_OFF;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    assign mode  = mode_q;
    assign phase = phase_q;

endmodule

// File: rtl/taillight_pattern_decoder.sv
// rtl/taillight_pattern_decoder.sv - two-side taillight bus monitor with conflict flag and error counter
module taillight_pattern_decoder
    import taillight_pkg::*;
#(
    parameter int STEP_CYCLES = 5,
    parameter int CNT_W       = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           left_taillight_control,
    input  logic [2:0]           right_taillight_control,
    output logic [1:0]           left_mode,
    output logic [1:0]           right_mode,
    output logic [1:0]           left_phase,
    output logic [1:0]           right_phase,
    output logic                 left_seq_err,
    output logic                 right_seq_err,
    output logic                 conflict,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [ERR_CNT_W:0] err_sum;

    taillight_side_decoder #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_left (
        .clk     (clk),
        .rst     (rst),
        .pattern (left_taillight_control),
        .mode    (left_mode),
        .phase   (left_phase),
        .seq_err (left_seq_err)
    );

    taillight_side_decoder #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_right (
        .clk     (clk),
        .rst     (rst),
        .pattern (right_taillight_control),
        .mode    (right_mode),
        .phase   (right_phase),
        .seq_err (right_seq_err)
    );

    // Brake on one side with brake+turn on the other is legal; only two animated sides conflict.
    assign conflict = (left_mode == MODE_TURN  || left_mode == MODE_BRAKE_TURN) &&
                      (right_mode == MODE_TURN || right_mode == MODE_BRAKE_TURN);

    assign err_sum = {1'b0, err_count} + {{ERR_CNT_W{1'b0}}, left_seq_err}
                                       + {{ERR_CNT_W{1'b0}}, right_seq_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_sum[ERR_CNT_W]) begin
            err_count <= '1;
        end else begin
            err_count <= err_sum[ERR_CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_taillight_pattern_decoder.sv
// tb/tb_taillight_pattern_decoder.sv - directed self-checking bench for taillight_pattern_decoder
module tb_taillight_pattern_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] lt;
    logic [2:0] rt;
    logic [1:0] lm;
    logic [1:0] rm;
    logic [1:0] lp;
    logic [1:0] rp;
    logic       lerr;
    logic       rerr;
    logic       conflict;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int lerr_seen = 0;
    int rerr_seen = 0;
    int base_l;
    int base_r;

    logic [2:0] tseq [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic [2:0] bseq [4] = '{3'b111, 3'b110, 3'b100, 3'b000};

    always #5 clk = ~clk;

    taillight_pattern_decoder dut (
        .clk                     (clk),
        .rst                     (rst),
        .left_taillight_control  (lt),
        .right_taillight_control (rt),
        .left_mode               (lm),
        .right_mode              (rm),
        .left_phase              (lp),
        .right_phase             (rp),
        .left_seq_err            (lerr),
        .right_seq_err           (rerr),
        .conflict                (conflict),
        .err_count               (err_count)
    );

    always @(posedge clk) begin
        lerr_seen <= lerr_seen + int'(lerr);
        rerr_seen <= rerr_seen + int'(rerr);
    end

    task automatic assert_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set(input logic [2:0] l, input logic [2:0] r);
        lt = l;
        rt = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set(3'b000, 3'b000);
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        assert_eq({tag, "_lmode"}, int'(lm), 0);
        assert_eq({tag, "_rmode"}, int'(rm), 0);
        assert_eq({tag, "_lphase"}, int'(lp), 0);
        assert_eq({tag, "_rphase"}, int'(rp), 0);
        assert_eq({tag, "_lerr"}, int'(lerr), 0);
        assert_eq({tag, "_rerr"}, int'(rerr), 0);
        assert_eq({tag, "_conflict"}, int'(conflict), 0);
        assert_eq({tag, "_errcnt"}, int'(err_count), 0);
    endtask

    initial begin
        // Reset with brake on both sides, then release.
        rst = 1'b1;
        set(3'b111, 3'b111);
        cyc(2);
        check_all_zero("t1_rst");
        rst = 1'b0;
        cyc(1);
        assert_eq("t1_lmode_n1", int'(lm), 0);
        cyc(1);
        assert_eq("t1_lmode_n2", int'(lm), 2);
        assert_eq("t1_rmode_n2", int'(rm), 2);

        // Left TURN, two full loops, then steady off.
        do_reset();
        cyc(2);
        base_l = lerr_seen;
        for (int lpi = 0; lpi < 2; lpi++) begin
            for (int s = 0; s < 4; s++) begin
                set(tseq[s], 3'b000);
                cyc(5);
                assert_eq($sformatf("t2_lmode_%0d_%0d", lpi, s), int'(lm), 1);
                assert_eq($sformatf("t2_lphase_%0d_%0d", lpi, s), int'(lp), s);
                assert_eq($sformatf("t2_conflict_%0d_%0d", lpi, s), int'(conflict), 0);
            end
        end
        cyc(6);
        assert_eq("t2_lmode_off", int'(lm), 0);
        cyc(2);
        assert_eq("t2_lerr_pulses", lerr_seen - base_l, 0);

        // Left brake steady, right BRAKE_TURN.
        do_reset();
        cyc(2);
        base_l = lerr_seen;
        base_r = rerr_seen;
        for (int s = 0; s < 4; s++) begin
            set(3'b111, bseq[s]);
            cyc(5);
            assert_eq($sformatf("t3_lmode_%0d", s), int'(lm), 2);
            assert_eq($sformatf("t3_rmode_%0d", s), int'(rm), (s == 0) ? 2 : 3);
            if (s != 0) assert_eq($sformatf("t3_rphase_%0d", s), int'(rp), s);
            assert_eq($sformatf("t3_conflict_%0d", s), int'(conflict), 0);
        end
        cyc(2);
        assert_eq("t3_lerr_pulses", lerr_seen - base_l, 0);
        assert_eq("t3_rerr_pulses", rerr_seen - base_r, 0);

        // Short 011 segment, then an illegal 010.
        do_reset();
        cyc(2);
        base_l = lerr_seen;
        base_r = rerr_seen;
        set(3'b001, 3'b000); cyc(5);
        set(3'b011, 3'b000); cyc(4);
        set(3'b111, 3'b000); cyc(5);
        set(3'b000, 3'b000); cyc(5);
        assert_eq("t4_lerr_pulses_1", lerr_seen - base_l, 1);
        assert_eq("t4_errcnt_1", int'(err_count), 1);
        set(3'b010, 3'b000); cyc(8);
        assert_eq("t4_lerr_pulses_2", lerr_seen - base_l, 2);
        assert_eq("t4_errcnt_2", int'(err_count), 2);
        assert_eq("t4_rerr_pulses", rerr_seen - base_r, 0);

        // Both sides TURN -> conflict; right drops to off.
        do_reset();
        cyc(3);
        set(3'b001, 3'b001);
        cyc(1);
        assert_eq("t5_conflict_n1", int'(conflict), 0);
        cyc(1);
        assert_eq("t5_conflict_n2", int'(conflict), 1);
        cyc(3);
        set(3'b011, 3'b011);
        cyc(5);
        assert_eq("t5_conflict_hold", int'(conflict), 1);
        set(3'b111, 3'b000);
        cyc(1);
        assert_eq("t5_conflict_clr_n1", int'(conflict), 1);
        cyc(1);
        assert_eq("t5_conflict_clr_n2", int'(conflict), 0);
        assert_eq("t5_lmode", int'(lm), 1);
        assert_eq("t5_rmode", int'(rm), 0);

        // Error flood saturates the counter; reset mid-sequence.
        do_reset();
        for (int i = 0; i < 160; i++) begin
            if (i % 2 == 0) set(3'b010, 3'b010);
            else            set(3'b101, 3'b101);
            cyc(1);
        end
        cyc(3);
        assert_eq("t6_errcnt_sat", int'(err_count), 255);
        set(3'b010, 3'b010);
        cyc(1);
        set(3'b101, 3'b101);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check_all_zero("t6_rst");
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
